// File: rtl/io_bridge_pkg.sv
// Shared register map and write-mask encodings for the CPU/RAM IO bridge.
package io_bridge_pkg;

  localparam int NUM_REGS    = 4;
  localparam int REG_IDX_W   = $clog2(NUM_REGS);
  localparam int NUM_BUTTONS = 3;
  localparam int LED_W       = 5;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_LED       = 2'd0,
    REG_BTN_STATE = 2'd1,
    REG_BTN_EDGE  = 2'd2,
    REG_TIMER     = 2'd3
  } reg_idx_e;

  localparam logic [4:0] WMASK_BYTE = 5'b00111;
  localparam logic [4:0] WMASK_HALF = 5'b01111;
  localparam logic [4:0] WMASK_WORD = 5'b11111;
  localparam logic [4:0] WMASK_NONE = 5'b00000;

  function automatic logic wmask_valid(input logic [4:0] mask);
    return (mask == WMASK_BYTE) || (mask == WMASK_HALF) || (mask == WMASK_WORD);
  endfunction

  // Partial writes keep the untouched upper bits of the old value.
  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [4:0]  mask);
    case (mask)
      WMASK_BYTE: return {old_val[31:8], wdata[7:0]};
      WMASK_HALF: return {old_val[31:16], wdata[15:0]};
      default:    return wdata;
    endcase
  endfunction

endpackage

// File: rtl/io_bridge_button_debouncer.sv
// Two-flop synchronizer plus stability counter for one raw push button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic button,
  output logic stable,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             sync;
  logic             differs;

  assign sync    = sync_q[1];
  assign differs = (sync != stable_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order or block order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      if (!differs) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Combinational pulse aligned with the edge that flips stable to 1.
  assign rise   = differs && (cnt_q == CNT_LAST) && sync;
  assign stable = stable_q;

endmodule

// File: rtl/io_bridge.sv
// Memory-port bridge: routes CPU accesses to external RAM or to a small IO
// register block (LEDs, debounced buttons with edge capture, free-running timer).
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int IO_SEL_BIT      = 22,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [31:0]            ADDR,
  input  logic [31:0]            WDATA,
  input  logic [4:0]             WMASK,
  input  logic [31:0]            RAM_RDATA,
  input  logic [NUM_BUTTONS-1:0] BUTTONS,
  output logic [31:0]            rdata,
  output logic [4:0]             ram_wmask,
  output logic [LED_W-1:0]       leds
);

  logic                   io_sel;
  reg_idx_e               reg_idx;
  logic                   io_we;
  logic [NUM_BUTTONS-1:0] btn_stable;
  logic [NUM_BUTTONS-1:0] btn_rise;
  logic [NUM_BUTTONS-1:0] edge_clr;
  logic [31:0]            io_rdata_d;

  logic [LED_W-1:0]       led_q;
  logic [NUM_BUTTONS-1:0] btn_edge_q;
  logic [31:0]            timer_q;
  logic                   io_sel_q;
  logic [31:0]            io_rdata_q;

  // Only a few address bits are decoded; the rest are don't-care here.
  logic unused_addr;
  assign unused_addr = ^ADDR;

  assign io_sel    = ADDR[IO_SEL_BIT];
  assign reg_idx   = reg_idx_e'(ADDR[3:2]);
  assign io_we     = io_sel && wmask_valid(WMASK);
  assign ram_wmask = io_sel ? WMASK_NONE : WMASK;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .CLK   (CLK),
      .RESETN(RESETN),
      .button(BUTTONS[i]),
      .stable(btn_stable[i]),
      .rise  (btn_rise[i])
    );
  end

  assign edge_clr = (io_we && reg_idx == REG_BTN_EDGE) ? WDATA[NUM_BUTTONS-1:0] : '0;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    io_rdata_d = '0;
    case (reg_idx)
      REG_LED:       io_rdata_d[LED_W-1:0]       = led_q;
      REG_BTN_STATE: io_rdata_d[NUM_BUTTONS-1:0] = btn_stable;
      REG_BTN_EDGE:  io_rdata_d[NUM_BUTTONS-1:0] = btn_edge_q;
      REG_TIMER:     io_rdata_d                  = timer_q;
      default:       io_rdata_d                  = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      led_q      <= '0;
      btn_edge_q <= '0;
      timer_q    <= '0;
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= io_sel;
      io_rdata_q <= io_rdata_d;

      if (io_we && reg_idx == REG_LED) begin
        led_q <= WDATA[LED_W-1:0];
      end

      // Set is OR-ed in after the clear so a coincident rise wins.
      btn_edge_q <= (btn_edge_q & ~edge_clr) | btn_rise;

      if (io_we && reg_idx == REG_TIMER) begin
        timer_q <= merge_write(timer_q, WDATA, WMASK);
      end else begin
        timer_q <= timer_q + 32'd1;
      end
    end
  end

  assign rdata = io_sel_q ? io_rdata_q : RAM_RDATA;
  assign leds  = led_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: reads queue an expected value, a monitor
// compares rdata one cycle later; combinational outputs are checked directly.
module tb_io_bridge;
  import io_bridge_pkg::*;

  localparam logic [31:0] A_LED   = 32'h0040_0000;
  localparam logic [31:0] A_STATE = 32'h0040_0004;
  localparam logic [31:0] A_EDGE  = 32'h0040_0008;
  localparam logic [31:0] A_TIMER = 32'h0040_000C;
  localparam logic [31:0] A_RAM   = 32'h0000_0010;

  logic        CLK;
  logic        RESETN;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [4:0]  WMASK;
  logic [31:0] RAM_RDATA;
  logic [2:0]  BUTTONS;
  logic [31:0] rdata;
  logic [4:0]  ram_wmask;
  logic [4:0]  leds;

  io_bridge #(
    .IO_SEL_BIT     (22),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .WMASK    (WMASK),
    .RAM_RDATA(RAM_RDATA),
    .BUTTONS  (BUTTONS),
    .rdata    (rdata),
    .ram_wmask(ram_wmask),
    .leds     (leds)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  // Simple synchronous RAM model: data for the address one cycle later.
  always @(posedge CLK) RAM_RDATA <= ram_fn(ADDR);

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic rd_req   = 1'b0;
  logic rd_stage = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge CLK) rd_stage <= rd_req;

  always @(negedge CLK) begin
    if (rd_stage) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got 0x%08h expected no pending read", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, rdata, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [4:0] m);
    ADDR  = a;
    WDATA = d;
    WMASK = m;
    tick();
    WMASK = WMASK_NONE;
    WDATA = '0;
  endtask

  task automatic read(input logic [31:0] a, input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.val  = exp;
    ADDR   = a;
    WMASK  = WMASK_NONE;
    exp_q.push_back(e);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    RESETN  = 1'b0;
    ADDR    = A_LED;
    WDATA   = 32'h0000_001F;
    WMASK   = WMASK_WORD;
    BUTTONS = 3'b000;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_io_ram_wmask", 32'(ram_wmask), 32'h0);
    check("reset_rdata_is_ram", rdata, RAM_RDATA);

    // First edge after release is a normal cycle: TIMER=1 after it.
    WMASK  = WMASK_NONE;
    WDATA  = '0;
    RESETN = 1'b1;
    tick();
    read(A_TIMER, "timer_after_reset", 32'h1);

    // LED write through IO space, then read back.
    ADDR  = A_LED;
    WDATA = 32'h0000_0015;
    WMASK = WMASK_WORD;
    #1;
    check("led_wr_ram_wmask", 32'(ram_wmask), 32'h0);
    tick();
    WMASK = WMASK_NONE;
    check("led_after_write", 32'(leds), 32'h15);
    read(A_LED, "led_readback", 32'h15);
    write(A_LED, 32'h0000_000A, 5'b00001);
    check("led_invalid_mask", 32'(leds), 32'h15);
    write(A_LED, 32'h0000_01F3, WMASK_HALF);
    check("led_half_write", 32'(leds), 32'h13);

    // RAM space passes the mask through and returns RAM data.
    ADDR  = A_RAM;
    WMASK = WMASK_WORD;
    #1;
    check("ram_wmask_word", 32'(ram_wmask), 32'h1F);
    WMASK = WMASK_BYTE;
    #1;
    check("ram_wmask_byte", 32'(ram_wmask), 32'h07);
    tick();
    WMASK = WMASK_NONE;
    read(A_RAM, "ram_read", ram_fn(A_RAM));

    write(A_STATE, 32'h0000_0007, WMASK_WORD);
    read(A_STATE, "btn_state_ro", 32'h0);

    // Short press is rejected.
    BUTTONS = 3'b001;
    idle(10);
    BUTTONS = 3'b000;
    idle(30);
    read(A_STATE, "glitch_state", 32'h0);
    read(A_EDGE, "glitch_edge", 32'h0);

    // Long press is accepted; reading the edge does not clear it.
    BUTTONS = 3'b001;
    idle(40);
    read(A_STATE, "press_state", 32'h1);
    read(A_EDGE, "press_edge", 32'h1);
    read(A_EDGE, "press_edge_reread", 32'h1);

    // Button 1 rise lands on edge 18 after the change, same edge as a W1C of 0x3.
    BUTTONS = 3'b011;
    idle(17);
    write(A_EDGE, 32'h0000_0003, WMASK_WORD);
    read(A_EDGE, "set_beats_clear", 32'h2);
    read(A_STATE, "two_pressed_state", 32'h3);
    write(A_EDGE, 32'h0000_0002, WMASK_BYTE);
    read(A_EDGE, "w1c_edge", 32'h0);

    // Timer wrap and partial writes.
    write(A_TIMER, 32'hFFFF_FFFE, WMASK_WORD);
    idle(2);
    read(A_TIMER, "timer_wrap", 32'h0);
    write(A_TIMER, 32'h1234_5678, WMASK_WORD);
    write(A_TIMER, 32'h0000_00AB, WMASK_BYTE);
    read(A_TIMER, "timer_byte", 32'h1234_56AB);
    write(A_TIMER, 32'h1234_5678, WMASK_WORD);
    write(A_TIMER, 32'h0000_BEEF, WMASK_HALF);
    read(A_TIMER, "timer_half", 32'h1234_BEEF);
    write(A_TIMER, 32'h0000_0100, WMASK_WORD);
    idle(4);
    read(A_TIMER, "timer_count", 32'h0000_0104);

    // Prepare a set edge bit, then reset in the middle of a debounce.
    BUTTONS = 3'b000;
    idle(25);
    BUTTONS = 3'b001;
    idle(20);
    read(A_EDGE, "pre_reset_edge", 32'h1);
    write(A_LED, 32'h0000_001F, WMASK_WORD);
    check("pre_reset_leds", 32'(leds), 32'h1F);
    BUTTONS = 3'b101;
    idle(8);
    RESETN = 1'b0;
    #1;
    check("mid_reset_leds", 32'(leds), 32'h0);
    check("mid_reset_rdata", rdata, RAM_RDATA);
    tick();
    RESETN = 1'b1;
    tick();
    read(A_TIMER, "timer_after_rereset", 32'h1);
    read(A_EDGE, "edge_after_reset", 32'h0);
    idle(14);
    read(A_STATE, "debounce_restart_early", 32'h0);
    read(A_STATE, "debounce_restart_done", 32'h5);
    read(A_EDGE, "edge_after_restart", 32'h5);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter IO_SEL_BIT, default 22, meaning the ADDR bit that selects IO space (1) over RAM (0).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable cycles required before a button change is accepted (min 2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  system clock; all state updates on the rising edge.
REQ-005 RESETN  in  1  asynchronous active-low reset.
REQ-006 ADDR  in  32  CPU byte address.
REQ-007 WDATA  in  32  CPU write data.
REQ-008 WMASK  in  5  CPU write mask: 5'b00111 byte, 5'b01111 half, 5'b11111 word; any other value means no write.
REQ-009 RAM_RDATA  in  32  RAM read data, one cycle after the RAM address.
REQ-010 BUTTONS  in  3  raw asynchronous push buttons, active high.
REQ-011 rdata  out  32  read data returned to the CPU.
REQ-012 ram_wmask  out  5  write mask forwarded to RAM.
REQ-013 leds  out  5  LED drive, equal to LED register bits 4:0.

Function
REQ-014 SHALL decode io_sel = ADDR[IO_SEL_BIT] combinationally; the register index is ADDR[3:2] (0 LED, 1 BTN_STATE, 2 BTN_EDGE, 3 TIMER).
REQ-015 SHALL drive ram_wmask = WMASK when io_sel=0 and 5'b00000 when io_sel=1, combinationally.
REQ-016 SHALL register io_sel and the selected IO register value every cycle, so IO reads have 1-cycle latency, matching RAM.
REQ-017 SHALL drive rdata = io_sel_q ? io_rdata_q : RAM_RDATA; unused IO bits read 0.
REQ-018 An IO write occurs when io_sel=1 and WMASK is a valid encoding, and takes effect at that rising edge.
REQ-019 LED register: a write of any valid width loads WDATA[4:0].
REQ-020 BTN_STATE is read-only (debounced levels in bits 2:0); writes are ignored.
REQ-021 BTN_EDGE bit n SHALL set on a debounced 0->1 of button n and clear on a write with WDATA[n]=1 (write-1-to-clear); when set and clear coincide, set wins.
REQ-022 TIMER is a free-running 32-bit up-counter that wraps 0xFFFFFFFF->0; a write replaces [7:0], [15:0] or [31:0] per WMASK, leaves the other bits unchanged, and overrides the increment in that cycle.
REQ-023 Each button SHALL pass through a 2-flop synchronizer followed by a debouncer.
REQ-024 Debouncer: when sync != stable, the counter increments; when sync == stable, the counter clears to 0; when the counter reaches DEBOUNCE_CYCLES-1 with sync != stable, stable <= sync and the counter clears.
REQ-025 A glitch shorter than DEBOUNCE_CYCLES SHALL never change stable or set an edge bit.
REQ-026 Reading BTN_EDGE SHALL NOT clear it.

Reset
REQ-027 While RESETN=0, the following SHALL be 0: LED, synchronizers, debounce counters, stable levels, BTN_EDGE, TIMER, io_sel_q and io_rdata_q. Consequently leds=0 and rdata=RAM_RDATA.
REQ-028 Reset asserted mid-debounce SHALL discard partial counts; after release, timing restarts from 0.
REQ-029 The first rising edge after RESETN deasserts SHALL be a normal operating cycle, with TIMER=1 after it.

Structure
REQ-030 Package io_bridge_pkg SHALL hold the register index constants, the WMASK encodings (byte, half, word, none) and the register count.
REQ-031 One sub-module, button_debouncer (synchronizer plus counter plus stable level plus rise pulse, parameter DEBOUNCE_CYCLES), SHALL be instantiated 3 times.
REQ-032 The RAM and the CPU SHALL stay outside this block; it sits between the CPU memory port and the RAM.

Verification
REQ-033 ADDR=0x00400000, WMASK=5'b11111, WDATA=0x15 -> ram_wmask=0, leds=5'b10101 after the edge; a read at the same address returns 0x15 one cycle later.
REQ-034 ADDR=0x00000010, WMASK=5'b11111 -> ram_wmask=5'b11111; rdata equals RAM_RDATA on the next cycle.
REQ-035 With DEBOUNCE_CYCLES=16: BUTTONS[0] high for 10 cycles -> BTN_STATE=0 and BTN_EDGE=0; high for 40 cycles -> BTN_STATE bit0=1, BTN_EDGE=0x1.
REQ-036 BTN_EDGE=0x1, then a rise on button 1 in the same cycle as a write of 0x3 to BTN_EDGE -> BTN_EDGE=0x2.
REQ-037 Write 0xFFFFFFFE to TIMER, then idle 2 cycles -> reads 0x00000000; a byte write of 0xAB over 0x12345678 -> 0x123456AB.
REQ-038 Assert RESETN=0 for 1 cycle mid-debounce with leds=0x1F -> leds=0 and BTN_EDGE=0 immediately; the next debounce requires a full 16 stable cycles.
